// File: rtl/clock_lock_seq_if.sv
// ---------------------------------------------------------------------------
// clock_lock_seq_if
// Signal bundle between the PLL lock supervisor and its environment.
//   pll_locked  raw PLL LOCK (asynchronous to clk_25m)
//   relock_req  single-cycle request to restart the lock sequence
//   pll_rst     PLL reset, active-high
//   clk_ready   generated clocks usable
//   fault       sticky failure indication
//   retry_cnt   consecutive failed lock attempts (RW bits)
//   state       debug state encoding
// Modports:
//   slave   the supervisor (reads lock/request, drives status)
//   master  the environment (drives lock/request, reads status)
// ---------------------------------------------------------------------------
interface clock_lock_seq_if #(
    parameter int RW = 2
);
    logic          pll_locked;
    logic          relock_req;
    logic          pll_rst;
    logic          clk_ready;
    logic          fault;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    state;

    modport slave (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output clk_ready,
        output fault,
        output retry_cnt,
        output state
    );

    modport master (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  clk_ready,
        input  fault,
        input  retry_cnt,
        input  state
    );
endinterface

// File: rtl/clock_lock_seq.sv
// ---------------------------------------------------------------------------
// clock_lock_seq
// PLL lock supervisor and clock-ready sequencer. Runs on the free-running
// board reference clock, pulses the PLL reset, waits for lock, requires the
// synchronised lock to hold for STABLE_CYCLES before declaring clk_ready,
// retries on timeout or unstable lock, and parks in a sticky FAULT state
// after too many consecutive failures. relock_req restarts from any state.
// Ports:
//   clk_25m  in   reference clock
//   rst_n    in   synchronous active-low reset
//   bus      slave modport of clock_lock_seq_if (lock input, relock request,
//            pll_rst / clk_ready / fault / retry_cnt / state outputs)
// ---------------------------------------------------------------------------
module clock_lock_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 2500,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic            clk_25m,
    input  logic            rst_n,
    clock_lock_seq_if.slave bus
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // The shared counter only ever has to reach the largest terminal value.
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [RW-1:0]          retry_reg, retry_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lock_s;
    logic                   fail;

    // Lock synchroniser: the raw PLL lock is asynchronous to clk_25m.
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign lock_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            state_reg <= ST_RESET;
            cnt_reg   <= '0;
            retry_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            retry_reg <= retry_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        fail       = 1'b0;

        if (bus.relock_req) begin
            // Restart from scratch; also restarts a pulse already in progress.
            state_next = ST_RESET;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
                    else                     cnt_next   = cnt_reg + CW'(1);
                end
                ST_WAIT_LOCK: begin
                    if (lock_s)                        state_next = ST_STABLE;
                    else if (cnt_reg == TIMEOUT_LAST)  fail       = 1'b1;
                    else                               cnt_next   = cnt_reg + CW'(1);
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        fail = 1'b1;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = ST_READY;
                        retry_next = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                ST_READY: begin
                    // Losing a good lock is a fresh attempt, not a failure.
                    if (!lock_s) state_next = ST_RESET;
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_RESET;
                end
            endcase

            if (fail) begin
                if (retry_reg == RETRY_MAX) begin
                    state_next = ST_FAULT;
                end else begin
                    retry_next = retry_reg + RW'(1);
                    state_next = ST_RESET;
                end
            end
        end

        if (state_next != state_reg) cnt_next = '0;
    end

    assign bus.pll_rst   = (state_reg == ST_RESET);
    assign bus.clk_ready = (state_reg == ST_READY);
    assign bus.fault     = (state_reg == ST_FAULT);
    assign bus.retry_cnt = retry_reg;
    assign bus.state     = state_reg;
endmodule
